// File: rtl/micro_pkg.sv
// micro_pkg
// Shared definitions for the microword encode/load path: word and address
// widths, field widths and bit positions inside the 33-bit microword, the
// field bundle struct, the loader state enum and the packing helper.
// The decode stage uses the same bit positions, so encode and decode stay
// bit-exact inverses of each other.
package micro_pkg;

  localparam int MICRO_W   = 33;
  localparam int ADDR_W    = 11;
  localparam int CNT_W     = 12;
  localparam int BUF_DEPTH = 2;

  localparam int ALU_W = 4;
  localparam int SH_W  = 2;
  localparam int KMX_W = 1;
  localparam int M_W   = 2;
  localparam int B_W   = 6;
  localparam int C_W   = 6;
  localparam int T_W   = 7;
  localparam int A_W   = 5;

  localparam int ALU_MSB = 32;
  localparam int ALU_LSB = 29;
  localparam int SH_MSB  = 28;
  localparam int SH_LSB  = 27;
  localparam int KMX_BIT = 26;
  localparam int M_MSB   = 25;
  localparam int M_LSB   = 24;
  localparam int B_MSB   = 23;
  localparam int B_LSB   = 18;
  localparam int C_MSB   = 17;
  localparam int C_LSB   = 12;
  localparam int T_MSB   = 11;
  localparam int T_LSB   = 5;
  localparam int A_MSB   = 4;
  localparam int A_LSB   = 0;

  typedef struct packed {
    logic [ALU_W-1:0] alu;
    logic [SH_W-1:0]  sh;
    logic [KMX_W-1:0] kmx;
    logic [M_W-1:0]   m;
    logic [B_W-1:0]   b;
    logic [C_W-1:0]   c;
    logic [T_W-1:0]   t;
    logic [A_W-1:0]   a;
  } micro_fields_t;

  typedef enum logic {
    IDLE,
    LOAD
  } state_t;

  // Places every field at its decode-stage bit position.
  function automatic logic [MICRO_W-1:0] pack_micro(input micro_fields_t f);
    logic [MICRO_W-1:0] w;
    w = '0;
    w[ALU_MSB:ALU_LSB] = f.alu;
    w[SH_MSB:SH_LSB]   = f.sh;
    w[KMX_BIT]         = f.kmx[0];
    w[M_MSB:M_LSB]     = f.m;
    w[B_MSB:B_LSB]     = f.b;
    w[C_MSB:C_LSB]     = f.c;
    w[T_MSB:T_LSB]     = f.t;
    w[A_MSB:A_LSB]     = f.a;
    return w;
  endfunction

endpackage

// File: rtl/micro_encode_loader_if.sv
// micro_encode_loader_if
// Bundles the two streaming sides of the loader:
//   field bundle in : ALU_OUT..A_OUT, in_valid (to loader), in_ready (from loader)
//   store write out : mem_we, mem_addr, mem_wdata (from loader), mem_ready (to loader)
// master = the environment (field source and control store),
// slave  = the loader itself.
interface micro_encode_loader_if;
  import micro_pkg::*;

  logic [ALU_W-1:0]   ALU_OUT;
  logic [SH_W-1:0]    SH_OUT;
  logic [KMX_W-1:0]   KMx_OUT;
  logic [M_W-1:0]     M_OUT;
  logic [B_W-1:0]     B_OUT;
  logic [C_W-1:0]     C_OUT;
  logic [T_W-1:0]     T_OUT;
  logic [A_W-1:0]     A_OUT;
  logic               in_valid;
  logic               in_ready;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [MICRO_W-1:0] mem_wdata;
  logic               mem_ready;

  modport master (
    output ALU_OUT, SH_OUT, KMx_OUT, M_OUT, B_OUT, C_OUT, T_OUT, A_OUT,
    output in_valid, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  ALU_OUT, SH_OUT, KMx_OUT, M_OUT, B_OUT, C_OUT, T_OUT, A_OUT,
    input  in_valid, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/micro_skid_fifo.sv
// micro_skid_fifo
// Two-entry FIFO of packed microwords sitting between the field input and the
// control-store write port.
// Ports: clk, rst_n (async active-low), push/din, pop/dout (head word),
//        full, empty.
// Push while full and pop while empty are ignored.
module micro_skid_fifo
  import micro_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [MICRO_W-1:0] din,
  input  logic               pop,
  output logic [MICRO_W-1:0] dout,
  output logic               full,
  output logic               empty
);

  // One-bit pointers: depth is fixed at two entries.
  logic [MICRO_W-1:0] mem [BUF_DEPTH];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == 2'(BUF_DEPTH));
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is cleared on reset so the head word reads as zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/micro_encode_loader.sv
// micro_encode_loader
// Packs separate microinstruction control fields into 33-bit microwords and
// streams them into the control store at auto-incrementing addresses.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             begin a load (only honoured in IDLE)
//   base_addr         first write address, latched on start
//   word_count        number of words to load, latched on start
//   bus (slave)       field bundle valid/ready in, store write we/ready out
//   busy              high while loading
//   done              one-cycle pulse after the final write (or after a
//                     zero-length start)
//   wrapped           sticky: address rolled over from 2047 to 0 this load
module micro_encode_loader
  import micro_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [CNT_W-1:0]      word_count,
  micro_encode_loader_if.slave  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  wrapped
);

  state_t             state;
  state_t             next_state;
  logic [ADDR_W-1:0]  addr_cnt;
  logic [CNT_W-1:0]   accept_rem;
  logic [CNT_W-1:0]   write_rem;
  micro_fields_t      fields;
  logic [MICRO_W-1:0] packed_word;
  logic [MICRO_W-1:0] head_word;
  logic               buf_full;
  logic               buf_empty;
  logic               push;
  logic               pop;

  // Gather the separate field inputs into one bundle and pack it.
  always_comb begin
    fields.alu  = bus.ALU_OUT;
    fields.sh   = bus.SH_OUT;
    fields.kmx  = bus.KMx_OUT;
    fields.m    = bus.M_OUT;
    fields.b    = bus.B_OUT;
    fields.c    = bus.C_OUT;
    fields.t    = bus.T_OUT;
    fields.a    = bus.A_OUT;
    packed_word = pack_micro(fields);
  end

  // Input is only accepted while words remain to be taken, so bundles
  // offered past the end of the load are left untouched.
  assign bus.in_ready  = (state == LOAD) && !buf_full && (accept_rem != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign bus.mem_we    = (state == LOAD) && !buf_empty;
  assign pop           = bus.mem_we && bus.mem_ready;
  assign bus.mem_addr  = addr_cnt;
  assign bus.mem_wdata = head_word;
  assign busy          = (state == LOAD);

  micro_skid_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (packed_word),
    .pop   (pop),
    .dout  (head_word),
    .full  (buf_full),
    .empty (buf_empty)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: a zero-length start never leaves IDLE; the load ends on the
  // handshake that writes the last word.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start && (word_count != '0)) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        if (pop && (write_rem == CNT_W'(1))) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Address and count tracking. Separate accept/write counters let the
  // input side finish early while the buffer is still draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt   <= '0;
      accept_rem <= '0;
      write_rem  <= '0;
      wrapped    <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr_cnt   <= base_addr;
            accept_rem <= word_count;
            write_rem  <= word_count;
            wrapped    <= 1'b0;
            done       <= (word_count == '0);
          end
        end
        LOAD: begin
          if (push) begin
            accept_rem <= accept_rem - CNT_W'(1);
          end
          if (pop) begin
            write_rem <= write_rem - CNT_W'(1);
            addr_cnt  <= addr_cnt + ADDR_W'(1);
            if (addr_cnt == '1) begin
              wrapped <= 1'b1;
            end
            if (write_rem == CNT_W'(1)) begin
              done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
